// File: rtl/emu_run_ctrl_if.sv
// Host-side command/response channel of the emulator run controller.
interface emu_run_ctrl_if;
    localparam int unsigned ARG_W = 64;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [ARG_W-1:0] cmd_arg;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_status;

    // Host side: issues commands, consumes responses.
    modport master (
        output cmd_valid, cmd_op, cmd_arg, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_status
    );

    // Controller side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, rsp_ready,
        output cmd_ready, rsp_valid, rsp_status
    );
endinterface

// File: rtl/emu_run_ctrl.sv
// Run-control sequencer: turns host PAUSE/RESUME/STEP/SET_COUNT commands into
// strobes toward the emulator harness and reports one status per command.
module emu_run_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic                 host_clk,
    input  logic                 host_rst_n,
    emu_run_ctrl_if.slave        host,
    input  logic                 run_mode,
    output logic                 do_pause,
    output logic                 do_resume,
    output logic                 step_write,
    output logic                 count_write,
    output logic [63:0]          step_wdata,
    output logic [63:0]          count_wdata
);

    localparam int unsigned ARG_W   = 64;
    localparam int unsigned TMR_W   = 32;
    localparam logic [TMR_W-1:0] TMO_LIMIT = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_MAX   = '1;

    localparam logic [1:0] OP_PAUSE  = 2'd0;
    localparam logic [1:0] OP_RESUME = 2'd1;
    localparam logic [1:0] OP_STEP   = 2'd2;
    localparam logic [1:0] OP_SET    = 2'd3;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_REJECT  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAUSE_WAIT,
        S_RESUME_WAIT,
        S_STEP_LOAD,
        S_STEP_RISE,
        S_STEP_FALL,
        S_RESP
    } state_t;

    state_t             r_state,       w_state_nxt;
    logic [TMR_W-1:0]   r_timer,       w_timer_nxt;
    logic               r_is_count,    w_is_count_nxt;
    logic [1:0]         r_rsp_status,  w_rsp_status_nxt;
    logic [ARG_W-1:0]   r_step_wdata,  w_step_wdata_nxt;
    logic [ARG_W-1:0]   r_count_wdata, w_count_wdata_nxt;
    logic               r_step_write,  w_step_write_nxt;
    logic               r_count_write, w_count_write_nxt;
    logic               r_do_pause,    w_do_pause_nxt;
    logic               r_do_resume,   w_do_resume_nxt;
    logic               r_cmd_ready,   w_cmd_ready_nxt;
    logic               r_rsp_valid,   w_rsp_valid_nxt;

    logic               w_accept;
    logic               w_rsp_hs;
    logic [TMR_W-1:0]   w_timer_inc;
    logic               w_timeout;

    assign w_accept    = host.cmd_valid && r_cmd_ready;
    assign w_rsp_hs    = r_rsp_valid && host.rsp_ready;
    // Saturating increment: the timer parks at all-ones instead of wrapping.
    assign w_timer_inc = (r_timer == TMR_MAX) ? r_timer : r_timer + TMR_W'(1);
    // Fires on the cycle whose end would bring the timer to the limit.
    assign w_timeout   = (TMO_LIMIT != '0) && (w_timer_inc >= TMO_LIMIT);

    // Next-state, response status and registered-output decode.
    always_comb begin
        w_state_nxt       = r_state;
        w_timer_nxt       = '0;
        w_is_count_nxt    = r_is_count;
        w_rsp_status_nxt  = r_rsp_status;
        w_step_wdata_nxt  = r_step_wdata;
        w_count_wdata_nxt = r_count_wdata;
        w_step_write_nxt  = 1'b0;
        w_count_write_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (host.cmd_op)
                        OP_PAUSE: begin
                            if (run_mode) begin
                                w_state_nxt = S_PAUSE_WAIT;
                            end else begin
                                w_state_nxt      = S_RESP;
                                w_rsp_status_nxt = ST_OK;
                            end
                        end
                        OP_RESUME: begin
                            if (!run_mode) begin
                                w_state_nxt = S_RESUME_WAIT;
                            end else begin
                                w_state_nxt      = S_RESP;
                                w_rsp_status_nxt = ST_OK;
                            end
                        end
                        OP_STEP: begin
                            if (run_mode || (host.cmd_arg == '0)) begin
                                w_state_nxt      = S_RESP;
                                w_rsp_status_nxt = ST_REJECT;
                            end else begin
                                w_state_nxt      = S_STEP_LOAD;
                                w_is_count_nxt   = 1'b0;
                                w_step_wdata_nxt = host.cmd_arg;
                                w_step_write_nxt = 1'b1;
                            end
                        end
                        default: begin
                            if (run_mode) begin
                                w_state_nxt      = S_RESP;
                                w_rsp_status_nxt = ST_REJECT;
                            end else begin
                                // STEP_LOAD doubles as the one-cycle count write.
                                w_state_nxt       = S_STEP_LOAD;
                                w_is_count_nxt    = 1'b1;
                                w_count_wdata_nxt = host.cmd_arg;
                                w_count_write_nxt = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_PAUSE_WAIT: begin
                if (!run_mode) begin
                    w_state_nxt      = S_RESP;
                    w_rsp_status_nxt = ST_OK;
                end else if (w_timeout) begin
                    w_state_nxt      = S_RESP;
                    w_rsp_status_nxt = ST_TIMEOUT;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            S_RESUME_WAIT: begin
                if (run_mode) begin
                    w_state_nxt      = S_RESP;
                    w_rsp_status_nxt = ST_OK;
                end else if (w_timeout) begin
                    w_state_nxt      = S_RESP;
                    w_rsp_status_nxt = ST_TIMEOUT;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            S_STEP_LOAD: begin
                if (r_is_count) begin
                    w_state_nxt      = S_RESP;
                    w_rsp_status_nxt = ST_OK;
                end else begin
                    w_state_nxt = S_STEP_RISE;
                end
            end
            S_STEP_RISE: begin
                if (run_mode) begin
                    w_state_nxt = S_STEP_FALL;
                end else if (w_timeout) begin
                    w_state_nxt      = S_RESP;
                    w_rsp_status_nxt = ST_TIMEOUT;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            S_STEP_FALL: begin
                if (!run_mode) begin
                    w_state_nxt      = S_RESP;
                    w_rsp_status_nxt = ST_OK;
                end else if (w_timeout) begin
                    w_state_nxt      = S_RESP;
                    w_rsp_status_nxt = ST_TIMEOUT;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            S_RESP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
        w_rsp_valid_nxt = (w_state_nxt == S_RESP);
        w_do_pause_nxt  = (w_state_nxt == S_PAUSE_WAIT);
        // Resume pulse only on the first cycle of a resume-type wait.
        w_do_resume_nxt = (w_state_nxt != r_state) &&
                          ((w_state_nxt == S_RESUME_WAIT) || (w_state_nxt == S_STEP_RISE));
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge host_clk) begin
        if (!host_rst_n) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_is_count    <= 1'b0;
            r_rsp_status  <= ST_OK;
            r_step_wdata  <= '0;
            r_count_wdata <= '0;
            r_step_write  <= 1'b0;
            r_count_write <= 1'b0;
            r_do_pause    <= 1'b0;
            r_do_resume   <= 1'b0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_is_count    <= w_is_count_nxt;
            r_rsp_status  <= w_rsp_status_nxt;
            r_step_wdata  <= w_step_wdata_nxt;
            r_count_wdata <= w_count_wdata_nxt;
            r_step_write  <= w_step_write_nxt;
            r_count_write <= w_count_write_nxt;
            r_do_pause    <= w_do_pause_nxt;
            r_do_resume   <= w_do_resume_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
        end
    end

    assign host.cmd_ready  = r_cmd_ready;
    assign host.rsp_valid  = r_rsp_valid;
    assign host.rsp_status = r_rsp_status;
    assign do_pause        = r_do_pause;
    assign do_resume       = r_do_resume;
    assign step_write      = r_step_write;
    assign count_write     = r_count_write;
    assign step_wdata      = r_step_wdata;
    assign count_wdata     = r_count_wdata;

endmodule

// File: tb/tb_emu_run_ctrl.sv
// Self-checking bench for emu_run_ctrl: directed corner cases followed by
// randomized commands, each checked cycle by cycle against a timing model.
module tb_emu_run_ctrl;

    localparam int T = 8;

    localparam logic [1:0] OP_PAUSE  = 2'd0;
    localparam logic [1:0] OP_RESUME = 2'd1;
    localparam logic [1:0] OP_STEP   = 2'd2;
    localparam logic [1:0] OP_SET    = 2'd3;
    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_REJECT  = 2'd2;

    logic        host_clk = 1'b0;
    logic        host_rst_n;
    logic        run_mode;
    logic        do_pause, do_resume, step_write, count_write;
    logic [63:0] step_wdata, count_wdata;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_step_wd;
    logic [63:0] exp_count_wd;

    emu_run_ctrl_if bus ();

    emu_run_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .host_clk    (host_clk),
        .host_rst_n  (host_rst_n),
        .host        (bus),
        .run_mode    (run_mode),
        .do_pause    (do_pause),
        .do_resume   (do_resume),
        .step_write  (step_write),
        .count_write (count_write),
        .step_wdata  (step_wdata),
        .count_wdata (count_wdata)
    );

    always #5 host_clk = ~host_clk;

    task automatic tick();
        @(posedge host_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Strobe vector is {do_pause, do_resume, step_write, count_write}.
    task automatic chk_cycle(input string tag, input logic [3:0] stb,
                             input logic rdy, input logic vld);
        chk({tag, "_strobes"},   64'({do_pause, do_resume, step_write, count_write}), 64'(stb));
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(rdy));
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(vld));
        chk({tag, "_step_wd"},   step_wdata,  exp_step_wd);
        chk({tag, "_count_wd"},  count_wdata, exp_count_wd);
    endtask

    // One command. k1/k2: wait-cycle index (1-based) in which run_mode flips
    // for the first/second wait phase, 0 = never flips. hold: rsp_ready-low cycles.
    task automatic run_cmd(input logic [1:0] op, input logic [63:0] arg, input logic rm0,
                           input int k1, input int k2, input int hold);
        int         t1, t2, rc, pz_end, res_c;
        logic       sw, cw;
        logic [1:0] st;
        logic [3:0] stb;
        t1 = 0; t2 = 0; rc = 1; pz_end = 0; res_c = 0; sw = 1'b0; cw = 1'b0; st = ST_OK;
        case (op)
            OP_PAUSE, OP_RESUME: begin
                if ((op == OP_PAUSE) == rm0) begin
                    t1 = k1;
                    if (k1 != 0 && k1 <= T) rc = k1 + 1;
                    else begin rc = T + 1; st = ST_TIMEOUT; end
                    if (op == OP_PAUSE) pz_end = rc - 1;
                    else res_c = 1;
                end
            end
            OP_STEP: begin
                if (rm0 || arg == 64'd0) st = ST_REJECT;
                else begin
                    sw = 1'b1; res_c = 2;
                    if (k1 != 0) t1 = 1 + k1;
                    if (k1 == 0 || k1 > T) begin
                        rc = 2 + T; st = ST_TIMEOUT;
                    end else begin
                        if (k2 != 0) t2 = 1 + k1 + k2;
                        if (k2 != 0 && k2 <= T) rc = 2 + k1 + k2;
                        else begin rc = 2 + k1 + T; st = ST_TIMEOUT; end
                    end
                end
            end
            default: begin
                if (rm0) st = ST_REJECT;
                else begin cw = 1'b1; rc = 2; end
            end
        endcase

        chk("accept_ready", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        run_mode      = rm0;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_arg   = {$urandom(), $urandom()};
        if (sw) exp_step_wd  = arg;
        if (cw) exp_count_wd = arg;
        for (int c = 1; c <= rc; c++) begin
            if (c > 1) tick();
            run_mode = rm0 ^ (t1 != 0 && c >= t1) ^ (t2 != 0 && c >= t2);
            stb = {(c <= pz_end), (c == res_c), (sw && c == 1), (cw && c == 1)};
            chk_cycle("run", stb, 1'b0, (c == rc));
        end
        chk("rsp_status", 64'(bus.rsp_status), 64'(st));
        for (int h = 0; h < hold; h++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = OP_SET;
            tick();
            chk_cycle("hold", 4'b0000, 1'b0, 1'b1);
            chk("hold_status", 64'(bus.rsp_status), 64'(st));
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        chk_cycle("post_hs", 4'b0000, 1'b1, 1'b0);
    endtask

    // Absolute run-time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_step_wd   = 64'd0;
        exp_count_wd  = 64'd0;
        host_rst_n    = 1'b0;
        run_mode      = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_arg   = 64'd0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        chk_cycle("reset", 4'b0000, 1'b0, 1'b0);
        chk("reset_status", 64'(bus.rsp_status), 64'd0);
        host_rst_n = 1'b1;
        tick();
        chk_cycle("reset_exit", 4'b0000, 1'b1, 1'b0);

        // Pause while running, emulator stops on wait cycle 6.
        run_cmd(OP_PAUSE, 64'd0, 1'b1, 6, 0, 0);
        // Pause while already paused.
        run_cmd(OP_PAUSE, 64'd0, 1'b0, 0, 0, 0);
        // Three-tick step: run_mode high for three cycles.
        run_cmd(OP_STEP, 64'd3, 1'b0, 1, 3, 1);
        // Rejections.
        run_cmd(OP_STEP, 64'd7, 1'b1, 0, 0, 0);
        run_cmd(OP_SET, 64'h1234, 1'b1, 0, 0, 0);
        run_cmd(OP_STEP, 64'd0, 1'b0, 0, 0, 0);
        run_cmd(OP_SET, 64'hDEAD_BEEF_0123_4567, 1'b0, 0, 0, 0);
        // Timeout boundaries.
        run_cmd(OP_PAUSE, 64'd0, 1'b1, 0, 0, 0);
        run_cmd(OP_PAUSE, 64'd0, 1'b1, T, 0, 0);
        run_cmd(OP_PAUSE, 64'd0, 1'b1, T + 1, 0, 0);
        run_cmd(OP_RESUME, 64'd0, 1'b0, T, 0, 0);
        run_cmd(OP_STEP, 64'd9, 1'b0, T, T + 1, 0);
        run_cmd(OP_STEP, 64'd2, 1'b0, 0, 0, 0);
        // Response back-pressure with a stray command offered.
        run_cmd(OP_RESUME, 64'd0, 1'b1, 0, 0, 10);

        // Reset while in STEP_FALL abandons the command.
        chk("rst_accept_ready", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_STEP;
        bus.cmd_arg   = 64'd5;
        run_mode      = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        exp_step_wd   = 64'd5;
        chk_cycle("rst_load", 4'b0010, 1'b0, 1'b0);
        tick();
        run_mode = 1'b1;
        chk_cycle("rst_rise", 4'b0100, 1'b0, 1'b0);
        tick();
        chk_cycle("rst_fall", 4'b0000, 1'b0, 1'b0);
        host_rst_n = 1'b0;
        tick();
        exp_step_wd  = 64'd0;
        exp_count_wd = 64'd0;
        chk_cycle("rst_mid", 4'b0000, 1'b0, 1'b0);
        chk("rst_mid_status", 64'(bus.rsp_status), 64'd0);
        host_rst_n = 1'b1;
        tick();
        chk_cycle("rst_after", 4'b0000, 1'b1, 1'b0);
        run_cmd(OP_PAUSE, 64'd0, 1'b1, 3, 0, 0);

        // Randomized commands.
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  op;
            logic [63:0] arg;
            op  = 2'($urandom_range(0, 3));
            arg = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) arg = 64'd0;
            run_cmd(op, arg, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                    int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
